dmem_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 (CPU load/store

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//    Shares the single-port data memory between two requesters: port 0 is the
//    CPU load/store path and port 1 is the loader/DMA that preloads and dumps
//    memory for test. Arbitration is round-robin. Only one transaction is in
//    flight at a time, and read data returns after a fixed latency. Every
//    strobe driven towards the memory comes straight from a flop.
//
// Parameters:
//    AW      address width in bits
//    DW      data width in bits
//    RD_LAT  cycles from mem_read asserted to mem_rdata valid (1..7)
//
// Ports:
//    clk                clock, all state updates on the rising edge
//    reset              synchronous, active-high reset
//    req0/req1          transaction request, held by the requester until gntN
//    we0/we1            1 = write, 0 = read, held with reqN
//    addr0/addr1        byte address, held with reqN
//    wdata0/wdata1      write data, held with reqN
//    gnt0/gnt1          one-cycle pulse: request accepted
//    rvalid0/rvalid1    one-cycle pulse: rdata holds the read result for that port
//    rdata              registered read data, stable until the next read return
//    busy               high whenever the arbiter is not idle
//    mem_addr           DataMemory Address (holds its value between transactions)
//    mem_wdata          DataMemory WriteData
//    mem_read           DataMemory MemoryRead
//    mem_write          DataMemory MemoryWrite
//    mem_rdata          DataMemory ReadData
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int AW     = 64,
   parameter int DW     = 64,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_WAIT
   } state_t;

   // The latency counter starts at 1 in ISSUE and the read completes when it
   // reaches this value.
   localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

   state_t        state;
   logic          last_gnt;
   logic          cur_port;
   logic [2:0]    lat_cnt;

   logic          pick1;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Round-robin choice. A lone request always wins. When both ports request,
   // the port that was not granted last wins. last_gnt resets to 1, so the
   // first tie after reset goes to port 0. The result is only used in IDLE.
   always_comb begin
      pick1     = req1 && (!req0 || !last_gnt);
      sel_we    = pick1 ? we1    : we0;
      sel_addr  = pick1 ? addr1  : addr0;
      sel_wdata = pick1 ? wdata1 : wdata0;
   end

   // Transaction sequencer. Grant and rvalid are single-cycle pulses, so they
   // default low each cycle. busy is updated together with every state change
   // so that it always equals (state != IDLE).
   // Writes take IDLE -> ISSUE -> IDLE.
   // Reads take IDLE -> ISSUE -> RD_WAIT (RD_LAT cycles) -> IDLE, and mem_read
   // and mem_addr are held steady for the whole read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         cur_port  <= 1'b0;
         lat_cnt   <= 3'd0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata     <= '0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_write <= sel_we;
                  mem_read  <= !sel_we;
                  gnt0      <= !pick1;
                  gnt1      <= pick1;
                  last_gnt  <= pick1;
                  cur_port  <= pick1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_write) begin
                  mem_write <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  lat_cnt <= 3'd1;
                  state   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  rdata    <= mem_rdata;
                  rvalid0  <= !cur_port;
                  rvalid1  <= cur_port;
                  mem_read <= 1'b0;
                  lat_cnt  <= 3'd0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            default: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
